// File: rtl/jtkunio_sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtkunio_sdram_pkg
// Description : Shared state encoding and burst helper for the SDRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package jtkunio_sdram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REF   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WWAIT = 3'd4
    } state_t;

    // Number of low address bits that wrap inside a burst.
    function automatic int burst_w(input int burst);
        if (burst >= 4)
            return 2;
        else if (burst == 2)
            return 1;
        else
            return 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtkunio_sdram_resp_mem.sv
`default_nettype none
// ============================================================================
// Module      : jtkunio_sdram_resp_mem
// Description : 4-bank 16-bit backing store, byte-masked write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module jtkunio_sdram_resp_mem #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [1:0]    wr_mask,
    input  logic          rd_en,
    input  logic [1:0]    rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] r_mem [0:(4<<AW)-1];
    logic [15:0] r_rd_data;

    // Contents are never reset so that a mid-burst reset keeps the loaded image.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!wr_mask[0]) r_mem[{wr_bank, wr_addr}][7:0]  <= wr_data[7:0];
            if (!wr_mask[1]) r_mem[{wr_bank, wr_addr}][15:8] <= wr_data[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rd_data <= '0;
        else if (rd_en)
            r_rd_data <= r_mem[{rd_bank, rd_addr}];
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/jtkunio_sdram_resp.sv
`default_nettype none
// ============================================================================
// Module      : jtkunio_sdram_resp
// Description : On-chip SDRAM stand-in: 4-bank round-robin reads, programming
//               port, SDRAM-like latency and periodic refresh windows.
// Revision    : 1.0 - initial release
// ============================================================================
module jtkunio_sdram_resp
    import jtkunio_sdram_pkg::*;
#(
    parameter int AW      = 12,
    parameter int LAT     = 3,
    parameter int BURST   = 2,
    parameter int WLAT    = 2,
    parameter int REF_PER = 384,
    parameter int REF_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] ba0_addr,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic [3:0]  ba_rd,
    output logic [3:0]  ba_ack,
    output logic [3:0]  ba_dst,
    output logic [3:0]  ba_dok,
    output logic [3:0]  ba_rdy,
    output logic [15:0] data_read,
    input  logic        downloading,
    input  logic [21:0] prog_addr,
    input  logic [15:0] prog_data,
    input  logic [1:0]  prog_mask,
    input  logic [1:0]  prog_ba,
    input  logic        prog_we,
    input  logic        prog_rd,
    output logic        prog_ack,
    output logic        prog_dst,
    output logic        prog_dok,
    output logic        prog_rdy
);

    localparam int            c_w         = burst_w(BURST);
    localparam logic [AW-1:0] c_lo_mask   = AW'((1 << c_w) - 1);
    localparam int            c_rw        = $clog2(REF_PER + 2);
    localparam logic [c_rw-1:0] c_ref_per = c_rw'(REF_PER);
    localparam logic [7:0]    c_lat_m1    = 8'(LAT - 1);
    localparam logic [7:0]    c_wlat_m1   = 8'(WLAT - 1);
    localparam logic [7:0]    c_ref_m1    = 8'(REF_CYC - 1);
    localparam logic [1:0]    c_last      = 2'(BURST - 1);

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic [1:0]      r_k;
    logic [1:0]      r_bank;
    logic [1:0]      r_rr;
    logic [AW-1:0]   r_addr;
    logic            r_prog;
    logic [c_rw-1:0] r_ref_cnt;
    logic [3:0]      r_ack, r_dst, r_dok, r_rdy;
    logic            r_pack, r_pdst, r_pdok, r_prdy;

    logic [AW-1:0]   w_bank_addr [4];
    logic [1:0]      w_grant;
    logic            w_found;
    logic            w_ref_due;
    logic            w_issue;
    logic            w_last;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [AW-1:0]   w_rd_addr;
    logic            w_unused;

    assign w_bank_addr[0] = ba0_addr[AW-1:0];
    assign w_bank_addr[1] = ba1_addr[AW-1:0];
    assign w_bank_addr[2] = ba2_addr[AW-1:0];
    assign w_bank_addr[3] = ba3_addr[AW-1:0];
    assign w_unused = &{1'b0, ba0_addr, ba1_addr, ba2_addr, ba3_addr, prog_addr};

    // Round-robin search starting at the bank after the last grant.
    always_comb begin
        w_grant = r_rr;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!w_found && ba_rd[2'(r_rr + 2'(i))]) begin
                w_found = 1'b1;
                w_grant = 2'(r_rr + 2'(i));
            end
        end
    end

    assign w_ref_due = (c_ref_per != '0) && (r_ref_cnt == c_ref_per);
    assign w_issue   = ((r_state == ST_WAIT) && (r_cnt == 8'd0)) || (r_state == ST_DATA);
    assign w_last    = (r_k == c_last);
    assign w_wr_en   = (r_state == ST_IDLE) && !w_ref_due && prog_we && !rst;
    assign w_rd_en   = w_issue && !rst;
    // Low address bits wrap within the burst without carrying upward.
    assign w_rd_addr = (r_addr & ~c_lo_mask) | ((r_addr + AW'(r_k)) & c_lo_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_k       <= '0;
            r_bank    <= '0;
            r_rr      <= '0;
            r_addr    <= '0;
            r_prog    <= 1'b0;
            r_ref_cnt <= '0;
            r_ack     <= '0;
            r_dst     <= '0;
            r_dok     <= '0;
            r_rdy     <= '0;
            r_pack    <= 1'b0;
            r_pdst    <= 1'b0;
            r_pdok    <= 1'b0;
            r_prdy    <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_dst  <= '0;
            r_dok  <= '0;
            r_rdy  <= '0;
            r_pack <= 1'b0;
            r_pdst <= 1'b0;
            r_pdok <= 1'b0;
            r_prdy <= 1'b0;
            if (r_ref_cnt != c_ref_per)
                r_ref_cnt <= r_ref_cnt + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_ref_due) begin
                        r_state   <= ST_REF;
                        r_cnt     <= c_ref_m1;
                        r_ref_cnt <= '0;
                    end else if (prog_we || prog_rd) begin
                        r_pack <= 1'b1;
                        r_bank <= prog_ba;
                        r_addr <= prog_addr[AW-1:0];
                        r_prog <= 1'b1;
                        r_k    <= '0;
                        if (prog_we) begin
                            r_state <= ST_WWAIT;
                            r_cnt   <= c_wlat_m1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_lat_m1;
                        end
                    end else if (!downloading && w_found) begin
                        r_ack[w_grant] <= 1'b1;
                        r_bank  <= w_grant;
                        r_addr  <= w_bank_addr[w_grant];
                        r_prog  <= 1'b0;
                        r_k     <= '0;
                        r_rr    <= w_grant + 2'd1;
                        r_state <= ST_WAIT;
                        r_cnt   <= c_lat_m1;
                    end
                end
                ST_REF, ST_WWAIT: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                        r_prdy  <= (r_state == ST_WWAIT);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WAIT, ST_DATA: begin
                    if (w_issue) begin
                        if (r_prog) begin
                            r_pdok <= 1'b1;
                            r_pdst <= (r_k == 2'd0);
                            r_prdy <= w_last;
                        end else begin
                            r_dok[r_bank] <= 1'b1;
                            r_dst[r_bank] <= (r_k == 2'd0);
                            r_rdy[r_bank] <= w_last;
                        end
                        r_k     <= r_k + 2'd1;
                        r_state <= w_last ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    jtkunio_sdram_resp_mem #(
        .AW (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_bank (prog_ba),
        .wr_addr (prog_addr[AW-1:0]),
        .wr_data (prog_data),
        .wr_mask (prog_mask),
        .rd_en   (w_rd_en),
        .rd_bank (r_bank),
        .rd_addr (w_rd_addr),
        .rd_data (data_read)
    );

    assign ba_ack   = r_ack;
    assign ba_dst   = r_dst;
    assign ba_dok   = r_dok;
    assign ba_rdy   = r_rdy;
    assign prog_ack = r_pack;
    assign prog_dst = r_pdst;
    assign prog_dok = r_pdok;
    assign prog_rdy = r_prdy;

endmodule
`default_nettype wire

// File: tb/tb_jtkunio_sdram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtkunio_sdram_resp
// Description : Self-checking bench for jtkunio_sdram_resp (scoreboard based).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtkunio_sdram_resp;

    localparam int LAT = 3, BURST = 2, WLAT = 2, REF_CYC = 4;
    localparam int c_norm = LAT + BURST;
    localparam int c_long = LAT + BURST + REF_CYC + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [21:0] ba_addr [4];
    logic [3:0]  ba_rd;
    logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0] data_read;
    logic        downloading;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask, prog_ba;
    logic        prog_we, prog_rd;
    logic        prog_ack, prog_dst, prog_dok, prog_rdy;

    logic        ref_rst;
    logic [21:0] ref_addr;
    logic [3:0]  ref_rd;
    logic [3:0]  ref_ack, ref_dst, ref_dok, ref_rdy;
    logic [15:0] ref_data;
    logic        ref_pack, ref_pdst, ref_pdok, ref_prdy;

    jtkunio_sdram_resp #(
        .AW(12), .LAT(LAT), .BURST(BURST), .WLAT(WLAT), .REF_PER(384), .REF_CYC(REF_CYC)
    ) u_dut (
        .clk(clk), .rst(rst),
        .ba0_addr(ba_addr[0]), .ba1_addr(ba_addr[1]), .ba2_addr(ba_addr[2]), .ba3_addr(ba_addr[3]),
        .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
        .data_read(data_read), .downloading(downloading),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_ba(prog_ba),
        .prog_we(prog_we), .prog_rd(prog_rd), .prog_ack(prog_ack), .prog_dst(prog_dst),
        .prog_dok(prog_dok), .prog_rdy(prog_rdy)
    );

    jtkunio_sdram_resp #(
        .AW(12), .LAT(LAT), .BURST(BURST), .WLAT(WLAT), .REF_PER(20), .REF_CYC(REF_CYC)
    ) u_ref (
        .clk(clk), .rst(ref_rst),
        .ba0_addr(ref_addr), .ba1_addr(ref_addr), .ba2_addr(ref_addr), .ba3_addr(ref_addr),
        .ba_rd(ref_rd), .ba_ack(ref_ack), .ba_dst(ref_dst), .ba_dok(ref_dok), .ba_rdy(ref_rdy),
        .data_read(ref_data), .downloading(1'b0),
        .prog_addr(22'd0), .prog_data(16'd0), .prog_mask(2'b00), .prog_ba(2'b00),
        .prog_we(1'b0), .prog_rd(1'b0), .prog_ack(ref_pack), .prog_dst(ref_pdst),
        .prog_dok(ref_pdok), .prog_rdy(ref_prdy)
    );

    typedef struct { int src; logic [15:0] data; int off; } exp_t;
    typedef struct { logic [1:0] ba; logic [21:0] addr; logic [15:0] data; logic [1:0] mask; } wr_t;
    typedef struct { int src; logic [1:0] ba; logic [21:0] addr; logic [15:0] e0; logic [15:0] e1; } rd_t;

    exp_t sb[$];
    int   total = 0, bad = 0;
    int   cyc = 0, ack_cyc = 0, wr_pend = 0;
    int   rr_ord [5] = '{0, 1, 2, 3, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: every data word is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        logic [4:0] m;
        if (|ba_ack || prog_ack) begin
            check("single_ack", $countones({prog_ack, ba_ack}), 1);
            ack_cyc = cyc;
        end
        if (|ba_dok || prog_dok) begin
            if (sb.size() == 0) begin
                check("unexpected_dok", {27'd0, prog_dok, ba_dok}, 0);
            end else begin
                e = sb.pop_front();
                m = 5'(1) << e.src;
                check("dok_src", {27'd0, prog_dok, ba_dok}, {27'd0, m});
                check("data", {16'd0, data_read}, {16'd0, e.data});
                check("dst", {27'd0, prog_dst, ba_dst}, (e.off == 0) ? {27'd0, m} : 32'd0);
                check("rdy", {27'd0, prog_rdy, ba_rdy}, (e.off == BURST - 1) ? {27'd0, m} : 32'd0);
                check("latency", cyc - ack_cyc, LAT + e.off);
            end
        end else begin
            if (|ba_dst || |ba_rdy || prog_dst)
                check("stray_strobe", {23'd0, prog_dst, ba_dst, ba_rdy}, 0);
            if (prog_rdy) begin
                check("wr_rdy_expected", (wr_pend > 0) ? 1 : 0, 1);
                check("wr_latency", cyc - ack_cyc, WLAT);
                if (wr_pend > 0) wr_pend--;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ack(input int src);
        logic got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            got = (src == 4) ? prog_ack : ba_ack[src];
        end
        check("ack_seen", {31'd0, got}, 1);
    endtask

    task automatic wait_drain();
        logic done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            tick();
            done = (sb.size() == 0) && (wr_pend == 0);
        end
        check("drain", {31'd0, done}, 1);
        if (!done) begin
            sb.delete();
            wr_pend = 0;
        end
    endtask

    task automatic do_write(input wr_t w, input logic also_rd);
        wr_pend++;
        prog_ba = w.ba; prog_addr = w.addr; prog_data = w.data; prog_mask = w.mask;
        prog_we = 1'b1; prog_rd = also_rd;
        wait_ack(4);
        prog_we = 1'b0; prog_rd = 1'b0;
        wait_drain();
    endtask

    task automatic push_burst(input int src, input logic [15:0] e0, input logic [15:0] e1);
        sb.push_back('{src: src, data: e0, off: 0});
        sb.push_back('{src: src, data: e1, off: 1});
    endtask

    task automatic do_read(input rd_t r);
        push_burst(r.src, r.e0, r.e1);
        if (r.src == 4) begin
            prog_ba = r.ba; prog_addr = r.addr; prog_rd = 1'b1;
            wait_ack(4);
            prog_rd = 1'b0;
        end else begin
            ba_addr[r.src] = r.addr; ba_rd[r.src] = 1'b1;
            wait_ack(r.src);
            ba_rd[r.src] = 1'b0;
        end
        wait_drain();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    wr_t wr_tab [10];
    rd_t rd_tab [6];

    initial begin
        int acks, last, nlong;
        logic got;
        wr_tab = '{
            '{2'd0, 22'h000, 16'h1111, 2'b00}, '{2'd0, 22'h001, 16'h2222, 2'b00},
            '{2'd1, 22'h010, 16'hA5A5, 2'b00}, '{2'd1, 22'h011, 16'h5A5A, 2'b00},
            '{2'd2, 22'h020, 16'hFFFF, 2'b00}, '{2'd2, 22'h021, 16'hBEEF, 2'b00},
            '{2'd3, 22'h030, 16'h3333, 2'b00}, '{2'd3, 22'h031, 16'h4444, 2'b00},
            '{2'd2, 22'h020, 16'h1234, 2'b10}, '{2'd3, 22'h031, 16'h55AA, 2'b01}
        };
        rd_tab = '{
            '{1, 2'd1, 22'h010,    16'hA5A5, 16'h5A5A},
            '{1, 2'd1, 22'h011,    16'h5A5A, 16'hA5A5},
            '{2, 2'd2, 22'h020,    16'hFF34, 16'hBEEF},
            '{3, 2'd3, 22'h031,    16'h5544, 16'h3333},
            '{0, 2'd0, 22'h3FF000, 16'h1111, 16'h2222},
            '{4, 2'd3, 22'h030,    16'h3333, 16'h5544}
        };

        rst = 1'b1; ref_rst = 1'b1; ba_rd = '0; ref_rd = '0; ref_addr = '0;
        for (int i = 0; i < 4; i++) ba_addr[i] = '0;
        downloading = 1'b0; prog_addr = '0; prog_data = '0; prog_mask = '0; prog_ba = '0;
        prog_we = 1'b0; prog_rd = 1'b0;
        repeat (3) tick();
        check("reset_strobes", {24'd0, ba_ack, ba_dst, ba_dok, ba_rdy} | {28'd0, prog_ack, prog_dst, prog_dok, prog_rdy}, 0);
        check("reset_data", {16'd0, data_read}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) do_write(wr_tab[i], 1'b0);
        for (int i = 0; i < 6; i++) do_read(rd_tab[i]);

        // Simultaneous write and read-back: only the write is carried out.
        do_write('{2'd0, 22'h001, 16'h7777, 2'b00}, 1'b1);
        do_read('{0, 2'd0, 22'h000, 16'h1111, 16'h7777});

        // All four banks requesting from a fresh pointer.
        pulse_reset();
        ba_addr[0] = 22'h000; ba_addr[1] = 22'h010; ba_addr[2] = 22'h020; ba_addr[3] = 22'h030;
        push_burst(0, 16'h1111, 16'h7777); push_burst(1, 16'hA5A5, 16'h5A5A);
        push_burst(2, 16'hFF34, 16'hBEEF); push_burst(3, 16'h3333, 16'h5544);
        push_burst(0, 16'h1111, 16'h7777);
        ba_rd = 4'b1111;
        acks = 0;
        for (int n = 0; n < 80 && acks < 5; n++) begin
            tick();
            if (|ba_ack) begin
                check("rr_order", {28'd0, ba_ack}, 32'(4'(1) << rr_ord[acks]));
                acks++;
            end
        end
        ba_rd = '0;
        check("rr_count", acks, 5);
        wait_drain();

        // Downloading blocks bank reads until it falls.
        pulse_reset();
        downloading = 1'b1; ba_addr[0] = 22'h000; ba_rd = 4'b0001;
        push_burst(0, 16'h1111, 16'h7777);
        got = 1'b0;
        repeat (8) begin
            tick();
            if (|ba_ack) got = 1'b1;
        end
        check("dl_no_ack", {31'd0, got}, 0);
        downloading = 1'b0;
        tick();
        check("dl_ack_next", {28'd0, ba_ack}, 32'h1);
        if (!ba_ack[0]) wait_ack(0);
        ba_rd = '0;
        wait_drain();

        // Reset during the first data word abandons the burst.
        sb.push_back('{src: 1, data: 16'hA5A5, off: 0});
        ba_addr[1] = 22'h010; ba_rd[1] = 1'b1;
        wait_ack(1);
        ba_rd[1] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            got = ba_dst[1];
        end
        check("rst_dst_seen", {31'd0, got}, 1);
        rst = 1'b1;
        tick();
        check("rst_strobes", {24'd0, ba_ack, ba_dst, ba_dok, ba_rdy} | {28'd0, prog_ack, prog_dst, prog_dok, prog_rdy}, 0);
        check("rst_data", {16'd0, data_read}, 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("rst_sb_empty", sb.size(), 0);
        sb.delete();
        do_read('{1, 2'd1, 22'h010, 16'hA5A5, 16'h5A5A});

        // Refresh windows with bank 0 requesting continuously.
        ref_rst = 1'b0; ref_rd = 4'b0001;
        last = -1; nlong = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (ref_ack[0]) begin
                if (last >= 0) begin
                    check("ref_interval", ((cyc - last == c_norm) || (cyc - last == c_long)) ? 1 : 0, 1);
                    if (cyc - last == c_long) nlong++;
                end
                last = cyc;
            end
        end
        ref_rd = '0;
        check("ref_windows", (nlong >= 5) ? 1 : 0, 1);
        check("ref_prog_idle", {28'd0, ref_pack, ref_pdst, ref_pdok, ref_prdy}, 0);

        repeat (10) tick();
        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
